calc_core: RTL and testbench

Parametrised arithmetic sequencer for the keypad calculator. It accepts decoded keypad digits and operator codes, builds signed operands, and chains operations: pressing an operator after a second operand evaluates the pending operation first. It computes add, subtract, multiply and (optionally) iterative signed divide, and reports overflow and divide-by-zero. It sits between the keypad decoder and the seven-segment output stage, replacing the separate load-A/load-B/load-R control sequencing.

---
 rtl/calc_if.sv | 16 +
 rtl/calc_core.sv | 222 ++++++++++++++++++++++
 tb/tb_calc_core.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/calc_if.sv
// calc_if: keypad strobes toward calc_core and display state back to the output stage.
interface calc_if #(parameter int WIDTH = 32);
  logic key_valid;
  logic [3:0] key_code;
  logic op_valid;
  logic [2:0] op;
  logic signed [WIDTH-1:0] value;
  logic [3:0] digit_count;
  logic showing_result;
  logic busy;
  logic error;
  modport master (output key_valid, key_code, op_valid, op,
                  input value, digit_count, showing_result, busy, error);
  modport slave (input key_valid, key_code, op_valid, op,
                 output value, digit_count, showing_result, busy, error);
endinterface

// File: rtl/calc_core.sv
// calc_core: keypad calculator sequencer (entry, chained add/sub/mul/div, overflow and error).
// Define CALC_DIV_EN to compile in the div operator and its iterative restoring divider.
module calc_core #(
  parameter int DIGITS = 6,
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  calc_if.slave bus
);
  typedef enum logic [2:0] {ENTRY_A, ENTRY_B, COMPUTE, RESULT, ERROR} state_e;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;
  localparam logic signed [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
  state_e state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic neg_q, neg_d, fresh_q, fresh_d, eq_q, eq_d;
  logic [3:0] cnt_q, cnt_d;
  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0] pend_q, pend_d, nxt_q, nxt_d;
  logic is_clr, is_eq, is_neg, is_arith, key_ok, done, div_err, r_err;
  logic [3:0] dig;
  logic signed [WIDTH-1:0] entry, r, div_q;
  logic signed [WIDTH:0] sum, dif;
  logic signed [2*WIDTH-1:0] prod;
  assign is_clr = bus.op_valid && bus.op == 3'b110;
  assign is_eq = bus.op_valid && bus.op == 3'b100;
  assign is_neg = bus.op_valid && bus.op == 3'b101;
`ifdef CALC_DIV_EN
  assign is_arith = bus.op_valid && !bus.op[2];
`else
  assign is_arith = bus.op_valid && !bus.op[2] && bus.op[1:0] != OP_DIV;
`endif
  assign key_ok = bus.key_valid && !bus.op_valid && bus.key_code <= 4'd9;
  assign dig = bus.key_code;
  assign entry = neg_q ? -$signed(mag_q) : $signed(mag_q);
  assign sum = (WIDTH+1)'(a_q) + (WIDTH+1)'(b_q);
  assign dif = (WIDTH+1)'(a_q) - (WIDTH+1)'(b_q);
  assign prod = (2*WIDTH)'(a_q) * (2*WIDTH)'(b_q);
  assign r = pend_q == OP_SUB ? dif[WIDTH-1:0] : pend_q == OP_MUL ? prod[WIDTH-1:0] :
             pend_q == OP_DIV ? div_q : sum[WIDTH-1:0];
  assign r_err = pend_q == OP_SUB ? dif[WIDTH] != dif[WIDTH-1] :
                 pend_q == OP_MUL ? prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}} :
                 pend_q == OP_DIV ? div_err : sum[WIDTH] != sum[WIDTH-1];
`ifdef CALC_DIV_EN
  localparam int IW = $clog2(WIDTH);
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, qn;
  logic [WIDTH:0] sh, diff;
  logic [IW-1:0] it_q, it_d;
  logic qneg_q, qneg_d, ge, start;
  // Magnitudes are divided unsigned; the quotient sign is reapplied at the end.
  assign start = state_q == ENTRY_B && (is_arith || is_eq);
  assign sh = {rem_q, quo_q[WIDTH-1]};
  assign diff = sh - {1'b0, dvs_q};
  assign ge = !diff[WIDTH];
  assign qn = {quo_q[WIDTH-2:0], ge};
  assign div_q = qneg_q ? -$signed(qn) : $signed(qn);
  assign div_err = b_q == '0 || (!qneg_q && qn[WIDTH-1]);
  assign done = pend_q != OP_DIV || it_q == IW'(WIDTH-1);
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    it_d = it_q;
    qneg_d = qneg_q;
    if (start) begin
      rem_d = '0;
      quo_d = a_q[WIDTH-1] ? -a_q : a_q;
      dvs_d = entry[WIDTH-1] ? -entry : entry;
      it_d = '0;
      qneg_d = a_q[WIDTH-1] ^ entry[WIDTH-1];
    end else if (state_q == COMPUTE) begin
      rem_d = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
      quo_d = qn;
      it_d = it_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      it_q <= '0;
      qneg_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      it_q <= it_d;
      qneg_q <= qneg_d;
    end
  end
`else
  assign div_q = '0;
  assign div_err = 1'b0;
  assign done = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    mag_d = mag_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
    fresh_d = fresh_q;
    eq_d = eq_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    pend_d = pend_q;
    nxt_d = nxt_q;
    if (is_clr) begin
      state_d = ENTRY_A;
      mag_d = '0;
      neg_d = 1'b0;
      cnt_d = '0;
      fresh_d = 1'b0;
      eq_d = 1'b0;
      a_d = '0;
      b_d = '0;
      res_d = '0;
      pend_d = OP_ADD;
      nxt_d = OP_ADD;
    end else begin
      case (state_q)
        ENTRY_A, ENTRY_B: begin
          if (key_ok) begin
            fresh_d = 1'b0;
            // Leading zeros neither grow the entry nor count as digits.
            if (cnt_q < 4'(DIGITS) && (mag_q != '0 || dig != 4'd0)) begin
              mag_d = mag_q * WIDTH'(10) + WIDTH'(dig);
              cnt_d = cnt_q + 4'd1;
            end
          end
          if (is_neg) begin
            neg_d = !neg_q;
            fresh_d = 1'b0;
          end
          if (is_arith && state_q == ENTRY_A) begin
            a_d = entry;
            pend_d = bus.op[1:0];
            mag_d = '0;
            neg_d = 1'b0;
            cnt_d = '0;
            fresh_d = 1'b1;
            state_d = ENTRY_B;
          end
          if ((is_arith || is_eq) && state_q == ENTRY_B) begin
            b_d = entry;
            nxt_d = bus.op[1:0];
            eq_d = is_eq;
            state_d = COMPUTE;
          end
        end
        COMPUTE: if (done) begin
          mag_d = '0;
          neg_d = 1'b0;
          cnt_d = '0;
          if (r_err) state_d = ERROR;
          else if (eq_q) begin
            res_d = r;
            state_d = RESULT;
          end else begin
            a_d = r;
            pend_d = nxt_q;
            fresh_d = 1'b1;
            state_d = ENTRY_B;
          end
        end
        RESULT: begin
          if (is_neg) begin
            if (res_q == MIN_INT) state_d = ERROR;
            else res_d = -res_q;
          end else if (is_arith) begin
            a_d = res_q;
            pend_d = bus.op[1:0];
            fresh_d = 1'b1;
            state_d = ENTRY_B;
          end else if (key_ok) begin
            mag_d = WIDTH'(dig);
            cnt_d = {3'b000, dig != 4'd0};
            neg_d = 1'b0;
            state_d = ENTRY_A;
          end
        end
        ERROR: state_d = ERROR;
        default: state_d = ENTRY_A;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ENTRY_A;
      mag_q <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
      fresh_q <= 1'b0;
      eq_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      pend_q <= OP_ADD;
      nxt_q <= OP_ADD;
    end else begin
      state_q <= state_d;
      mag_q <= mag_d;
      neg_q <= neg_d;
      cnt_q <= cnt_d;
      fresh_q <= fresh_d;
      eq_q <= eq_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      pend_q <= pend_d;
      nxt_q <= nxt_d;
    end
  end
  // A fresh second operand shows the running accumulator until typing starts.
  assign bus.value = state_q == ERROR ? '0 : state_q == RESULT ? res_q :
                     (state_q == ENTRY_B && fresh_q) ? a_q : entry;
  assign bus.digit_count = (state_q == RESULT || state_q == ERROR) ? 4'd0 : cnt_q;
  assign bus.showing_result = state_q == RESULT;
  assign bus.busy = state_q == COMPUTE;
  assign bus.error = state_q == ERROR;
endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: directed vector table plus multi-cycle sequences for calc_core.
module tb_calc_core;
  localparam int W = 32;
  localparam int I = 0, K = 1, O = 2, B = 3;
  localparam int ADD = 0, SUB = 1, MUL = 2, DIV = 3, EQ = 4, NEG = 5, CLR = 6, RSV = 7;
`ifdef CALC_DIV_EN
  localparam int LONG_OP = DIV, BUSY_N = W, LONG_RES = 14;
`else
  localparam int LONG_OP = MUL, BUSY_N = 1, LONG_RES = 700;
`endif
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  calc_if #(.WIDTH(W)) bus ();
  calc_core #(.DIGITS(6), .WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    int kind;
    int key;
    int op;
    logic signed [W-1:0] v;
    int cnt;
    logic sr, bz, er;
  } vec_t;
  vec_t vq[$];
  int pass_n = 0, tot_n = 0;
  task automatic vec(input int kind, input int key, input int op, input int v, input int cnt,
                     input logic sr, input logic bz, input logic er);
    vec_t t;
    t.kind = kind; t.key = key; t.op = op; t.v = W'(v); t.cnt = cnt; t.sr = sr; t.bz = bz; t.er = er;
    vq.push_back(t);
  endtask
  task automatic drive(input int kind, input int key, input int op);
    bus.key_valid = kind[0];
    bus.key_code = 4'(key);
    bus.op_valid = kind[1];
    bus.op = 3'(op);
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.op_valid = 1'b0;
  endtask
  task automatic chk(input string nm, input longint act, input longint exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic chk_out(input string nm, input logic signed [W-1:0] v, input int cnt,
                         input logic sr, input logic bz, input logic er);
    tot_n++;
    if (bus.value === v && bus.digit_count === 4'(cnt) && bus.showing_result === sr &&
        bus.busy === bz && bus.error === er) pass_n++;
    else $display("FAIL %s: got value=%0d cnt=%0d sr=%b busy=%b err=%b expected value=%0d cnt=%0d sr=%b busy=%b err=%b",
                  nm, bus.value, bus.digit_count, bus.showing_result, bus.busy, bus.error, v, cnt, sr, bz, er);
  endtask
  task automatic run_busy(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask
  task automatic keys(input int n);
    int d[$];
    d = {};
    while (n > 0) begin
      d.push_front(n % 10);
      n = n / 10;
    end
    foreach (d[j]) drive(K, d[j], 0);
  endtask
  initial begin
    int n, m;
    reset = 1'b1;
    bus.key_valid = 1'b0; bus.key_code = 4'd0; bus.op_valid = 1'b0; bus.op = 3'd0;
    @(negedge clk);
    @(negedge clk);
    chk_out("reset_state", 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    chk_out("after_reset", 0, 0, 0, 0, 0);
    vec(K, 1, 0, 1, 1, 0, 0, 0);
    vec(K, 2, 0, 12, 2, 0, 0, 0);
    vec(K, 3, 0, 123, 3, 0, 0, 0);
    vec(O, 0, ADD, 123, 0, 0, 0, 0);
    vec(K, 4, 0, 4, 1, 0, 0, 0);
    vec(K, 5, 0, 45, 2, 0, 0, 0);
    vec(O, 0, EQ, 45, 2, 0, 1, 0);
    vec(I, 0, 0, 168, 0, 1, 0, 0);
    vec(I, 0, 0, 168, 0, 1, 0, 0);
    vec(O, 0, CLR, 0, 0, 0, 0, 0);
    vec(K, 7, 0, 7, 1, 0, 0, 0);
    vec(O, 0, MUL, 7, 0, 0, 0, 0);
    vec(K, 6, 0, 6, 1, 0, 0, 0);
    vec(O, 0, SUB, 6, 1, 0, 1, 0);
    vec(I, 0, 0, 42, 0, 0, 0, 0);
    vec(K, 2, 0, 2, 1, 0, 0, 0);
    vec(O, 0, EQ, 2, 1, 0, 1, 0);
    vec(I, 0, 0, 40, 0, 1, 0, 0);
    vec(O, 0, NEG, -40, 0, 1, 0, 0);
    vec(O, 0, ADD, -40, 0, 0, 0, 0);
    vec(K, 3, 0, 3, 1, 0, 0, 0);
    vec(O, 0, EQ, 3, 1, 0, 1, 0);
    vec(I, 0, 0, -37, 0, 1, 0, 0);
    vec(K, 5, 0, 5, 1, 0, 0, 0);
    vec(O, 0, EQ, 5, 1, 0, 0, 0);
    vec(O, 0, RSV, 5, 1, 0, 0, 0);
    vec(B, 4, SUB, 5, 0, 0, 0, 0);
    vec(K, 9, 0, 9, 1, 0, 0, 0);
    vec(O, 0, EQ, 9, 1, 0, 1, 0);
    vec(I, 0, 0, -4, 0, 1, 0, 0);
    vec(O, 0, CLR, 0, 0, 0, 0, 0);
    vec(K, 0, 0, 0, 0, 0, 0, 0);
    vec(K, 0, 0, 0, 0, 0, 0, 0);
    vec(K, 3, 0, 3, 1, 0, 0, 0);
    vec(K, 0, 0, 30, 2, 0, 0, 0);
    vec(O, 0, CLR, 0, 0, 0, 0, 0);
    m = 0;
    for (int d = 1; d <= 6; d++) begin
      m = m * 10 + d;
      vec(K, d, 0, m, d, 0, 0, 0);
    end
    vec(K, 7, 0, 123456, 6, 0, 0, 0);
    vec(O, 0, NEG, -123456, 6, 0, 0, 0);
    vec(O, 0, NEG, 123456, 6, 0, 0, 0);
    vec(O, 0, CLR, 0, 0, 0, 0, 0);
    m = 0;
    for (int d = 1; d <= 6; d++) begin
      m = m * 10 + 9;
      vec(K, 9, 0, m, d, 0, 0, 0);
    end
    vec(O, 0, MUL, 999999, 0, 0, 0, 0);
    m = 0;
    for (int d = 1; d <= 6; d++) begin
      m = m * 10 + 9;
      vec(K, 9, 0, m, d, 0, 0, 0);
    end
    vec(O, 0, EQ, 999999, 6, 0, 1, 0);
    vec(I, 0, 0, 0, 0, 0, 0, 1);
    vec(K, 5, 0, 0, 0, 0, 0, 1);
    vec(O, 0, MUL, 0, 0, 0, 0, 1);
    vec(O, 0, NEG, 0, 0, 0, 0, 1);
    vec(O, 0, CLR, 0, 0, 0, 0, 0);
    foreach (vq[i]) begin
      drive(vq[i].kind, vq[i].key, vq[i].op);
      chk_out($sformatf("vec%0d", i), vq[i].v, vq[i].cnt, vq[i].sr, vq[i].bz, vq[i].er);
    end
    // long operation: 100 op 7
    drive(O, 0, CLR);
    keys(100);
    drive(O, 0, LONG_OP);
    keys(7);
    drive(O, 0, EQ);
    run_busy(n);
    chk("long_busy_cycles", n, BUSY_N);
    chk_out("long_result", LONG_RES, 0, 1, 0, 0);
`ifdef CALC_DIV_EN
    drive(O, 0, CLR);
    keys(5);
    drive(O, 0, DIV);
    drive(K, 0, 0);
    drive(O, 0, EQ);
    run_busy(n);
    chk("div0_busy_cycles", n, W);
    chk_out("div0_error", 0, 0, 0, 0, 1);
    drive(O, 0, CLR);
    chk_out("div0_clear", 0, 0, 0, 0, 0);
    keys(7);
    drive(O, 0, NEG);
    drive(O, 0, DIV);
    keys(2);
    drive(O, 0, EQ);
    run_busy(n);
    chk_out("div_neg", -3, 0, 1, 0, 0);
`else
    drive(O, 0, CLR);
    keys(8);
    drive(O, 0, DIV);
    chk_out("div_ignored", 8, 1, 0, 0, 0);
    drive(K, 2, 0);
    chk_out("div_ignored_next", 82, 2, 0, 0, 0);
`endif
    // reset mid-operation
    drive(O, 0, CLR);
    keys(100);
    drive(O, 0, LONG_OP);
    keys(7);
    drive(O, 0, EQ);
    repeat (BUSY_N >= 5 ? 4 : 0) @(negedge clk);
    chk("busy_before_reset", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_out("reset_mid_op", 0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk_out("reset_mid_op_later", 0, 0, 0, 0, 0);
    // clear mid-operation
    keys(100);
    drive(O, 0, LONG_OP);
    keys(7);
    drive(O, 0, EQ);
    repeat (BUSY_N >= 5 ? 4 : 0) @(negedge clk);
    chk("busy_before_clear", bus.busy, 1);
    drive(O, 0, CLR);
    chk_out("clear_mid_op", 0, 0, 0, 0, 0);
    repeat (40) @(negedge clk);
    chk_out("clear_mid_op_later", 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
